// File: rtl/mult_pkg.sv
// Shared definitions for the unsigned multiplier datapath: operand/product
// widths, transmitter state encodings and a parity helper used by shift_out.
package mult_pkg;

  localparam int PRODUCT_WIDTH = 24;
  localparam int OPERAND_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SHIFTING = 2'b01,
    DONE     = 2'b10,
    PARITY   = 2'b11
  } so_state_e;

  // Even parity of a product word (XOR of all bits).
  function automatic logic even_parity(input logic [PRODUCT_WIDTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/shift_out_if.sv
// Parallel-in / serial-out handshake bundle between the product source,
// the shift_out transmitter and the downstream serial consumer.
interface shift_out_if #(
  parameter int WIDTH = mult_pkg::PRODUCT_WIDTH
);

  logic [WIDTH-1:0] p_parallel;
  logic             sp;
  logic             p_out;
  logic             p_valid;
  logic             fp;

  // Producer/consumer side: supplies the word and start, observes the stream.
  modport master (
    output p_parallel,
    output sp,
    input  p_out,
    input  p_valid,
    input  fp
  );

  // Transmitter side.
  modport slave (
    input  p_parallel,
    input  sp,
    output p_out,
    output p_valid,
    output fp
  );

endinterface

// File: rtl/shift_out_rise_detect.sv
// rise_detect: registers a level input and flags its low-to-high transition
// for one cycle. The register resets to RESET_VAL; resetting to 1 means a
// level already high when reset releases is not reported as a rising edge.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q_r;

  // Delay the input by one cycle for edge comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q_r <= RESET_VAL;
    end else begin
      d_q_r <= d;
    end
  end

  assign rise = d & ~d_q_r;

endmodule

// File: rtl/shift_out.sv
// shift_out: parallel-to-serial transmitter for the multiplier product.
// Captures the word on a rising edge of sp and sends it MSB first, one bit
// per clock, with p_valid marking data bits; fp flags completion.
// Optional build macro SHIFT_OUT_PARITY_EN appends one even-parity bit after
// bit 0 (extra PARITY state, fp one cycle later).
// Outputs are registered; their next values are decoded from the next state
// so the first data bit still appears the cycle after the start edge.
module shift_out
  import mult_pkg::*;
#(
  parameter  int WIDTH = PRODUCT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  shift_out_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  so_state_e         state_r, state_nxt_s;
  logic [WIDTH-1:0]  shreg_r, shreg_nxt_s;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic              start_s;
  logic              p_out_r, p_valid_r, fp_r;
  logic              p_out_nxt_s, p_valid_nxt_s, fp_nxt_s;
`ifdef SHIFT_OUT_PARITY_EN
  logic              parity_r, parity_nxt_s;
`endif

  rise_detect #(
    .RESET_VAL (1'b1)
  ) u_sp_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bus.sp),
    .rise  (start_s)
  );

  // Next-state, shift register, counter and parity capture.
  always_comb begin
    state_nxt_s  = state_r;
    shreg_nxt_s  = shreg_r;
    count_nxt_s  = count_r;
`ifdef SHIFT_OUT_PARITY_EN
    parity_nxt_s = parity_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start_s) begin
          shreg_nxt_s  = bus.p_parallel;
          count_nxt_s  = {CNT_W{1'b0}};
          state_nxt_s  = SHIFTING;
`ifdef SHIFT_OUT_PARITY_EN
          parity_nxt_s = even_parity(bus.p_parallel);
`endif
        end else begin
          state_nxt_s = state_r;
        end
      end
      SHIFTING: begin
        shreg_nxt_s = {shreg_r[WIDTH-2:0], 1'b0};
        count_nxt_s = count_r + CNT_ONE;
        if (count_r == LAST_CNT) begin
`ifdef SHIFT_OUT_PARITY_EN
          state_nxt_s = PARITY;
`else
          state_nxt_s = DONE;
`endif
        end else begin
          state_nxt_s = SHIFTING;
        end
      end
`ifdef SHIFT_OUT_PARITY_EN
      PARITY: begin
        state_nxt_s = DONE;
      end
`endif
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state; p_out is 0 whenever no bit is sent.
  always_comb begin
    p_out_nxt_s   = 1'b0;
    p_valid_nxt_s = 1'b0;
    fp_nxt_s      = 1'b0;
    case (state_nxt_s)
      SHIFTING: begin
        p_out_nxt_s   = shreg_nxt_s[WIDTH-1];
        p_valid_nxt_s = 1'b1;
      end
`ifdef SHIFT_OUT_PARITY_EN
      PARITY: begin
        p_out_nxt_s   = parity_nxt_s;
        p_valid_nxt_s = 1'b1;
      end
`endif
      DONE: begin
        fp_nxt_s = 1'b1;
      end
      default: begin
        p_out_nxt_s   = 1'b0;
        p_valid_nxt_s = 1'b0;
        fp_nxt_s      = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      shreg_r   <= {WIDTH{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      p_out_r   <= 1'b0;
      p_valid_r <= 1'b0;
      fp_r      <= 1'b0;
`ifdef SHIFT_OUT_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      shreg_r   <= shreg_nxt_s;
      count_r   <= count_nxt_s;
      p_out_r   <= p_out_nxt_s;
      p_valid_r <= p_valid_nxt_s;
      fp_r      <= fp_nxt_s;
`ifdef SHIFT_OUT_PARITY_EN
      parity_r  <= parity_nxt_s;
`endif
    end
  end

  assign bus.p_out   = p_out_r;
  assign bus.p_valid = p_valid_r;
  assign bus.fp      = fp_r;

endmodule
